// File: rtl/wash_if.sv
// Handshake bundle between the program-setting/display logic and the wash sequencer.
// The master side issues commands and the descriptor; the slave side reports status and actuator drives.
interface wash_if;
    logic        start;
    logic        pause;
    logic        tick;
    logic [25:0] sourceData;
    logic [25:0] outData;
    logic [2:0]  phase;
    logic [3:0]  phaseRemain;
    logic [6:0]  totalRemain;
    logic        busy;
    logic        done;
    logic        waterValve;
    logic        motorSlow;
    logic        motorFast;
    logic        drainValve;

    modport master (
        output start, pause, tick, sourceData,
        input  outData, phase, phaseRemain, totalRemain, busy, done,
               waterValve, motorSlow, motorFast, drainValve
    );

    modport slave (
        input  start, pause, tick, sourceData,
        output outData, phase, phaseRemain, totalRemain, busy, done,
               waterValve, motorSlow, motorFast, drainValve
    );
endinterface

// File: rtl/wash_sequencer.sv
// Walks the eight phase fields of a packed 26-bit wash program, counting each down on 1 Hz ticks
// and publishing the live remaining-time descriptor alongside the actuator drives.
module wash_sequencer (
    input  logic  cp,
    input  logic  rst,
    wash_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEEK  = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  phase_q, phase_d;
    logic [25:0] shadow_q, shadow_d;
    logic [3:0]  cur_s;
    logic [6:0]  total_s;
    logic        water_s, slow_s, fast_s, drain_s;

    // Fields 1 and 5 are 4 bits wide; the rest are 3 bits and are zero-extended.
    function automatic logic [3:0] get_field(input logic [25:0] d, input logic [2:0] idx);
        case (idx)
            3'd0:    get_field = {1'b0, d[25:23]};
            3'd1:    get_field = d[22:19];
            3'd2:    get_field = {1'b0, d[18:16]};
            3'd3:    get_field = {1'b0, d[15:13]};
            3'd4:    get_field = {1'b0, d[12:10]};
            3'd5:    get_field = d[9:6];
            3'd6:    get_field = {1'b0, d[5:3]};
            3'd7:    get_field = {1'b0, d[2:0]};
            default: get_field = 4'd0;
        endcase
    endfunction

    function automatic logic [25:0] set_field(input logic [25:0] d, input logic [2:0] idx,
                                              input logic [3:0] v);
        logic [25:0] r;
        r = d;
        case (idx)
            3'd0:    r[25:23] = v[2:0];
            3'd1:    r[22:19] = v;
            3'd2:    r[18:16] = v[2:0];
            3'd3:    r[15:13] = v[2:0];
            3'd4:    r[12:10] = v[2:0];
            3'd5:    r[9:6]   = v;
            3'd6:    r[5:3]   = v[2:0];
            3'd7:    r[2:0]   = v[2:0];
            default: r = d;
        endcase
        return r;
    endfunction

    assign cur_s = get_field(shadow_q, phase_q);

    // State, phase index and shadow descriptor registers.
    always_ff @(posedge cp) begin
        if (rst) begin
            state_q  <= S_IDLE;
            phase_q  <= 3'd0;
            shadow_q <= 26'd0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            shadow_q <= shadow_d;
        end
    end

    // Next-state, phase advance and countdown of the active field.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        shadow_d = shadow_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    shadow_d = bus.sourceData;
                    phase_d  = 3'd0;
                    state_d  = S_SEEK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SEEK: begin
                if (cur_s != 4'd0) begin
                    state_d = S_RUN;
                end else if (phase_q == 3'd7) begin
                    state_d = S_DONE;
                end else begin
                    phase_d = phase_q + 3'd1;
                end
            end
            S_RUN: begin
                // Pause wins over a coincident tick, so that tick is lost.
                if (bus.pause) begin
                    state_d = S_PAUSE;
                end else if (bus.tick && (cur_s != 4'd0)) begin
                    shadow_d = set_field(shadow_q, phase_q, cur_s - 4'd1);
                    if (cur_s == 4'd1) begin
                        if (phase_q == 3'd7) begin
                            state_d = S_DONE;
                        end else begin
                            phase_d = phase_q + 3'd1;
                            state_d = S_SEEK;
                        end
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            S_PAUSE: begin
                if (!bus.pause) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_PAUSE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Status and actuator decode from registered state only.
    always_comb begin
        water_s = 1'b0;
        slow_s  = 1'b0;
        fast_s  = 1'b0;
        drain_s = 1'b0;
        total_s = 7'd0;
        for (int i = 0; i < 8; i++) begin
            total_s = total_s + {3'd0, get_field(shadow_q, 3'(i))};
        end
        if (state_q == S_RUN) begin
            case (phase_q)
                3'd0, 3'd4: water_s = 1'b1;
                3'd1, 3'd5: slow_s  = 1'b1;
                3'd2, 3'd6: drain_s = 1'b1;
                3'd3, 3'd7: begin
                    fast_s  = 1'b1;
                    drain_s = 1'b1;
                end
                default: water_s = 1'b0;
            endcase
        end else begin
            water_s = 1'b0;
        end
    end

    assign bus.outData     = shadow_q;
    assign bus.phase       = phase_q;
    assign bus.phaseRemain = cur_s;
    assign bus.totalRemain = total_s;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.waterValve  = water_s;
    assign bus.motorSlow   = slow_s;
    assign bus.motorFast   = fast_s;
    assign bus.drainValve  = drain_s;

endmodule

// File: tb/tb_wash_sequencer.sv
// Scoreboard bench for wash_sequencer: stimulus queues expected status snapshots, and a monitor
// compares one snapshot each time the remaining total changes or done pulses.
module tb_wash_sequencer;

    logic cp = 1'b0;
    logic rst;
    wash_if bus ();

    wash_sequencer dut (.cp(cp), .rst(rst), .bus(bus));

    always #5 cp = ~cp;

    typedef struct {
        logic [6:0] tot;
        logic [2:0] ph;
        logic [3:0] rem;
        logic [3:0] act;
        logic       dn;
        logic       bsy;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc_cnt  = 0;
    bit   mon_en   = 1'b0;
    logic [6:0] prev_tot = 7'd0;

    // {waterValve, motorSlow, motorFast, drainValve} per phase while running
    logic [3:0] act_tbl [8] = '{4'b1000, 4'b0100, 4'b0001, 4'b0011,
                                4'b1000, 4'b0100, 4'b0001, 4'b0011};
    int def_lens  [8] = '{3, 10, 4, 5, 3, 8, 4, 5};
    int skip_lens [8] = '{0, 0, 4, 5, 3, 8, 0, 0};
    int zero_lens [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    localparam logic [25:0] DEF_DESC  = 26'b011_1010_100_101_011_1000_100_101;
    localparam logic [25:0] SKIP_DESC = 26'b000_0000_100_101_011_1000_000_000;

    function automatic logic [3:0] acts();
        return {bus.waterValve, bus.motorSlow, bus.motorFast, bus.drainValve};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input int tot, input int ph, input int rem, input logic [3:0] act,
                                input logic dn, input int cyc);
        exp_t e;
        e.tot = 7'(tot);
        e.ph  = 3'(ph);
        e.rem = 4'(rem);
        e.act = act;
        e.dn  = dn;
        e.bsy = 1'b1;
        e.cyc = cyc;
        return e;
    endfunction

    // Hand model of the observable events of one program run.
    task automatic push_program(input int lens[8], input int done_cyc);
        int  tot;
        bool_tail: begin end
        tot = 0;
        for (int p = 0; p < 8; p++) tot += lens[p];
        if (tot == 0) begin
            q.push_back(mk(0, 7, 0, 4'b0000, 1'b1, done_cyc));
        end else begin
            q.push_back(mk(tot, 0, lens[0], 4'b0000, 1'b0, -1));
            for (int p = 0; p < 8; p++) begin
                for (int r = lens[p] - 1; r >= 0; r--) begin
                    tot--;
                    if (r > 0) begin
                        q.push_back(mk(tot, p, r, act_tbl[p], 1'b0, -1));
                    end else if (p == 7) begin
                        q.push_back(mk(0, 7, 0, 4'b0000, 1'b1, -1));
                    end else begin
                        q.push_back(mk(tot, p + 1, lens[p + 1], 4'b0000, 1'b0, -1));
                        if (tot == 0) q.push_back(mk(0, 7, 0, 4'b0000, 1'b1, -1));
                    end
                end
            end
        end
    endtask

    task automatic launch(input logic [25:0] d, input int lens[8]);
        int n;
        int sum;
        sum = 0;
        for (int p = 0; p < 8; p++) sum += lens[p];
        @(negedge cp);
        bus.sourceData = d;
        bus.start      = 1'b1;
        n = cyc_cnt + 1;
        // All-zero: 8 SEEK cycles after the start edge, so done shows after edge n+8.
        push_program(lens, (sum == 0) ? n + 8 : -1);
        @(negedge cp);
        bus.start = 1'b0;
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            @(negedge cp);
            bus.tick = 1'b1;
            @(negedge cp);
            bus.tick = 1'b0;
            repeat (2) @(negedge cp);
        end
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        while (q.size() != 0 && k < 60) begin
            @(negedge cp);
            k++;
        end
        chk({nm, "_pending_events"}, 32'(q.size()), 32'd0);
    endtask

    always @(posedge cp) cyc_cnt <= cyc_cnt + 1;

    // Monitor: one expected snapshot per total change or done pulse.
    always @(posedge cp) begin
        exp_t e;
        #2;
        if (mon_en) begin
            if ((bus.totalRemain !== prev_tot) || (bus.done !== 1'b0)) begin
                if (q.size() == 0) begin
                    chk("unexpected_event_total", 32'(bus.totalRemain), 32'(prev_tot));
                end else begin
                    e = q.pop_front();
                    chk("totalRemain", 32'(bus.totalRemain), 32'(e.tot));
                    chk("phase", 32'(bus.phase), 32'(e.ph));
                    chk("phaseRemain", 32'(bus.phaseRemain), 32'(e.rem));
                    chk("actuators", 32'(acts()), 32'(e.act));
                    chk("done", 32'(bus.done), 32'(e.dn));
                    chk("busy", 32'(bus.busy), 32'(e.bsy));
                    if (e.cyc >= 0) chk("done_cycle", 32'(cyc_cnt), 32'(e.cyc));
                end
            end
            prev_tot = bus.totalRemain;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.pause      = 1'b0;
        bus.tick       = 1'b0;
        bus.sourceData = 26'd0;
        repeat (2) @(negedge cp);
        rst = 1'b0;
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_outData", 32'(bus.outData), 32'd0);
        chk("reset_total", 32'(bus.totalRemain), 32'd0);
        chk("reset_act", 32'(acts()), 32'd0);
        chk("reset_phase", 32'(bus.phase), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        prev_tot = 7'd0;
        mon_en   = 1'b1;

        // Full default program
        launch(DEF_DESC, def_lens);
        tick_n(42);
        drain("default");
        @(negedge cp);
        chk("default_busy_after", 32'(bus.busy), 32'd0);

        // Skip leading and trailing zero phases
        launch(SKIP_DESC, skip_lens);
        chk("skip_seek0_phase", 32'(bus.phase), 32'd0);
        chk("skip_seek0_act", 32'(acts()), 32'd0);
        @(negedge cp);
        chk("skip_seek1_phase", 32'(bus.phase), 32'd1);
        chk("skip_seek1_act", 32'(acts()), 32'd0);
        @(negedge cp);
        chk("skip_seek2_phase", 32'(bus.phase), 32'd2);
        chk("skip_seek2_act", 32'(acts()), 32'd0);
        @(negedge cp);
        chk("skip_run2_phase", 32'(bus.phase), 32'd2);
        chk("skip_run2_act", 32'(acts()), 32'b0001);
        tick_n(20);
        drain("skip");

        // All-zero descriptor: done timing, never any actuator
        launch(26'd0, zero_lens);
        for (int i = 0; i < 10; i++) begin
            chk("zero_act", 32'(acts()), 32'd0);
            @(negedge cp);
        end
        drain("zero");
        chk("zero_busy_after", 32'(bus.busy), 32'd0);

        // Pause with a coincident tick while wash holds 7
        launch(DEF_DESC, def_lens);
        tick_n(6);
        chk("pre_pause_rem", 32'(bus.phaseRemain), 32'd7);
        @(negedge cp);
        bus.pause = 1'b1;
        bus.tick  = 1'b1;
        @(negedge cp);
        bus.tick = 1'b0;
        chk("pause_rem", 32'(bus.phaseRemain), 32'd7);
        chk("pause_act", 32'(acts()), 32'd0);
        tick_n(2);
        chk("pause_rem_after_ticks", 32'(bus.phaseRemain), 32'd7);
        chk("pause_phase", 32'(bus.phase), 32'd1);
        @(negedge cp);
        bus.pause = 1'b0;
        repeat (2) @(negedge cp);
        chk("resume_act", 32'(acts()), 32'b0100);
        tick_n(36);
        drain("pause");

        // Reset at phase 5
        launch(DEF_DESC, def_lens);
        tick_n(27);
        chk("pre_reset_phase", 32'(bus.phase), 32'd5);
        @(negedge cp);
        q.delete();
        q.push_back(mk(0, 0, 0, 4'b0000, 1'b0, -1));
        q[0].bsy = 1'b0;
        rst = 1'b1;
        bus.tick = 1'b1;
        @(negedge cp);
        rst = 1'b0;
        bus.tick = 1'b0;
        chk("midrst_outData", 32'(bus.outData), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_phase", 32'(bus.phase), 32'd0);
        drain("reset");

        // Start while busy is ignored
        launch(DEF_DESC, def_lens);
        tick_n(5);
        @(negedge cp);
        bus.sourceData = 26'h3FF_FFFF;
        bus.start      = 1'b1;
        @(negedge cp);
        bus.start = 1'b0;
        chk("restart_phase", 32'(bus.phase), 32'd1);
        chk("restart_outData", 32'(bus.outData), 32'(26'b000_1000_100_101_011_1000_100_101));
        tick_n(37);
        drain("restart");

        repeat (3) @(negedge cp);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wash_sequencer.md
# wash_sequencer

Executes a packed 26-bit washing program descriptor, as produced by the program-setting logic on `sourceData`. The block latches the descriptor on `start` and walks its eight phase fields in order, skipping zero-length phases. It counts each active phase down on 1 Hz `tick` enables and drives the water, motor and drain actuator outputs. It publishes the live remaining-time descriptor, in the same 26-bit format, so the display path can show the program counting down.

## Interface
Parameters: none. Field layout is fixed.
- `cp` input 1: system clock; all state updates on posedge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: launch request; sampled only in IDLE.
- `pause` input 1: level; holds the countdown while high.
- `tick` input 1: one-cycle 1 Hz enable pulse.
- `sourceData` input 26: program descriptor. Fields MSB→LSB, phase index 0..7:
  - 0 water-in [25:23]
  - 1 wash [22:19]
  - 2 drain [18:16]
  - 3 spin [15:13]
  - 4 water-in [12:10]
  - 5 rinse [9:6]
  - 6 drain [5:3]
  - 7 spin [2:0]
- `outData` output 26: live shadow descriptor. Completed phases read 0; the current field holds its remaining count.
- `phase` output 3: current phase index.
- `phaseRemain` output 4: current field value, zero-extended.
- `totalRemain` output 7: sum of all eight shadow fields (max 72).
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse on completion.
- `waterValve`, `motorSlow`, `motorFast`, `drainValve` output 1 each: actuator drives.

## Operation
- States: IDLE, SEEK, RUN, PAUSE, DONE.
- Reset: state IDLE, shadow = 0, `phase` = 0. All outputs read 0.
- IDLE:
  - `start`=1: shadow ← `sourceData`, `phase` ← 0, go to SEEK.
  - `start` is ignored in every other state.
- SEEK (one field per cycle):
  - If field[`phase`] ≠ 0: go to RUN.
  - Else if `phase` = 7: go to DONE.
  - Else `phase` ← `phase`+1 and stay in SEEK.
- RUN:
  - `pause`=1: go to PAUSE. No decrement that cycle, even if `tick`=1.
  - Else on `tick`: field[`phase`] ← field−1.
  - If the field was 1: at `phase` = 7 go to DONE; otherwise `phase`+1 and go to SEEK.
- PAUSE:
  - Ticks are ignored.
  - `pause`=0: return to RUN on the next edge.
- DONE:
  - `done`=1 for exactly this cycle.
  - Next state is IDLE. Shadow stays 0, `phase` keeps its final value until the next `start`.
- Actuators are asserted only in RUN, decoded from `phase`:
  - `waterValve`: phases 0, 4.
  - `motorSlow`: phases 1, 5.
  - `motorFast`: phases 3, 7.
  - `drainValve`: phases 2, 3, 6, 7.
  - All actuators are 0 in IDLE, SEEK, PAUSE and DONE.
- Arithmetic:
  - Decrement applies only to nonzero fields, so there is no wrap.
  - `totalRemain` is a combinational zero-extended 7-bit sum.

## Timing
- `start` at edge N: SEEK at phase 0 from N+1.
- Each zero field costs one SEEK cycle. An all-zero descriptor gives SEEK N+1..N+8, DONE at N+9, IDLE at N+10.
- A phase of value v needs exactly v RUN-state ticks. A tick arriving during SEEK, PAUSE or DONE is dropped.
- Outputs are registered-state decodes; no input→output combinational path except through the shadow register.
- `rst` mid-run returns to IDLE on the next edge and zeroes shadow and all outputs. It overrides `start`, `tick` and `pause` in the same cycle.
- `pause` already high when SEEK enters RUN: one RUN cycle with no decrement, then PAUSE.

## Test plan
- Reset then idle: hold `rst` 2 cycles -> `busy`=0, `outData`=0, `totalRemain`=0, all actuators 0.
- Full default program:
  - Stimulus: load 26'b011_1010_100_101_011_1000_100_101, pulse `start`, one `tick` every 4 cycles.
  - Required: `totalRemain`=42 after load, decreasing by 1 per RUN tick.
  - Required: `waterValve` for 3 ticks, then `motorSlow` for 10 ticks.
  - Required: `done` pulses once after 42 ticks, then `busy`=0.
- Skip phases:
  - Stimulus: descriptor 26'b000_0000_100_101_011_1000_000_000.
  - Required: `phase` goes 0→1→2 in SEEK cycles with no actuators, then RUN at phase 2 with `drainValve`=1.
  - Required: phases 6 and 7 are skipped, `done` after 20 ticks.
- All-zero descriptor: `start` at edge N -> `done`=1 exactly at N+9, no actuator ever asserted.
- Pause:
  - Stimulus: in wash with `phaseRemain`=7, assert `pause` with `tick` the same cycle.
  - Required: `phaseRemain` stays 7 and actuators drop while paused. After release, the next RUN tick gives 6.
- Reset mid-run and restart:
  - Stimulus: assert `rst` at phase 5.
  - Required: IDLE, `outData`=0 next cycle.
  - Stimulus: `start` while busy (re-run the program, then pulse `start` mid-run).
  - Required: ignored; `phase` and fields are unchanged.
